// File: rtl/if_fetch_queue.sv
// Fetch stage: drives the instruction ROM from the PC and queues {pc, inst} pairs for decode.
// Entries reach decode one cycle after the fetch; a full queue stalls fetch unless the head pops that cycle.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          DEPTH    = 4,
  parameter int          PC_W     = 32,
  parameter int          INST_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_inst_en,
  output logic [PC_W-1:0]            rom_inst_addr,
  input  logic [INST_W-1:0]          rom_inst,
  input  logic                       flush,
  input  logic [PC_W-1:0]            flush_pc,
  input  logic                       branch_flag,
  input  logic [PC_W-1:0]            branch_target,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [PC_W-1:0]            id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]   r_pc;
  logic              r_ce;
  logic [CW-1:0]     r_cnt;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];

  logic w_redirect;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_redirect = flush | branch_flag;
  assign w_full     = (r_cnt == CW'(DEPTH));
  // Redirect kills the head combinationally so decode never sees a wrong-path entry.
  assign id_valid   = (r_cnt != '0) & ~w_redirect;
  assign w_pop      = id_valid & id_ready;
  assign w_push     = r_ce & ~w_redirect & (~w_full | w_pop);

  assign rom_inst_en   = w_push;
  assign rom_inst_addr = r_pc;
  assign id_pc         = r_pc_mem[r_rptr];
  assign id_inst       = r_inst_mem[r_rptr];
  assign q_count       = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc   <= RESET_PC[PC_W-1:0];
      r_ce   <= 1'b0;
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_ce <= 1'b1;
      if (w_redirect) begin
        r_pc   <= flush ? flush_pc : branch_target;
        r_cnt  <= '0;
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) begin
          r_pc   <= r_pc + PC_W'(4);
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= r_pc;
      r_inst_mem[r_wptr] <= rom_inst;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model compared every cycle, plus directed literal checks.
module tb_if_fetch_queue;
  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h1c000000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rom_inst_en;
  logic [PC_W-1:0]   rom_inst_addr;
  logic [INST_W-1:0] rom_inst;
  logic              flush = 1'b0;
  logic [PC_W-1:0]   flush_pc = '0;
  logic              branch_flag = 1'b0;
  logic [PC_W-1:0]   branch_target = '0;
  logic              id_ready = 1'b0;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic [2:0]        q_count;

  always #5 clk = ~clk;

  if_fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst),
    .rom_inst_en(rom_inst_en), .rom_inst_addr(rom_inst_addr), .rom_inst(rom_inst),
    .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .q_count(q_count)
  );

  // Combinational ROM contents: a fixed scramble of the address.
  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9e3779b9;
  endfunction
  assign rom_inst = rom_f(rom_inst_addr);

  logic [31:0] m_pc;
  bit          m_ce;
  ent_t        mq[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          bad_fetch = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_pc = RPC;
    m_ce = 1'b0;
    mq.delete();
  endtask

  task automatic drive(input bit rdy, input bit fl, input logic [31:0] fpc,
                       input bit br, input logic [31:0] bt);
    id_ready = rdy; flush = fl; flush_pc = fpc; branch_flag = br; branch_target = bt;
    if (!rst) model_reset();
    #1;
  endtask

  // Compare DUT against the model for the current inputs, then advance one clock.
  task automatic step();
    bit redir, exp_valid, pop, exp_en;
    ent_t e;
    redir     = flush | branch_flag;
    exp_valid = (mq.size() != 0) && !redir;
    pop       = exp_valid && id_ready;
    exp_en    = m_ce && !redir && ((mq.size() < DEPTH) || pop);
    chk("en", 64'(rom_inst_en), 64'(exp_en));
    chk("addr", 64'(rom_inst_addr), 64'(m_pc));
    chk("valid", 64'(id_valid), 64'(exp_valid));
    chk("count", 64'(q_count), 64'(mq.size()));
    if (exp_valid) begin
      chk("id_pc", 64'(id_pc), 64'(mq[0].pc));
      chk("id_inst", 64'(id_inst), 64'(mq[0].inst));
    end
    if (rom_inst_en === 1'b1 && rom_inst_addr == 32'h1c000200) bad_fetch++;
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      if (redir) begin
        m_pc = flush ? flush_pc : branch_target;
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (exp_en) begin
          e.pc = m_pc; e.inst = rom_f(m_pc);
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
      m_ce = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    drive(rdy, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic restart(input bit rdy);
    rst = 1'b0; idle(rdy); step();
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // Reset release with id_ready held high
    idle(1'b1);
    chk("rst_en", 64'(rom_inst_en), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_count", 64'(q_count), 64'd0);
    step();
    rst = 1'b1;
    idle(1'b1);
    chk("t1_cyc1_en", 64'(rom_inst_en), 64'd0);
    step();
    idle(1'b1);
    chk("t1_cyc2_en", 64'(rom_inst_en), 64'd1);
    chk("t1_cyc2_addr", 64'(rom_inst_addr), 64'h1c000000);
    step();
    idle(1'b1);
    chk("t1_cyc3_valid", 64'(id_valid), 64'd1);
    chk("t1_cyc3_pc", 64'(id_pc), 64'h1c000000);
    chk("t1_cyc3_inst", 64'(id_inst), 64'(rom_f(32'h1c000000)));
    step();
    idle(1'b1);
    chk("t1_cyc4_pc", 64'(id_pc), 64'h1c000004);
    step();
    repeat (4) begin idle(1'b1); step(); end

    // Fill then stall
    restart(1'b0);
    idle(1'b0); step();
    repeat (4) begin idle(1'b0); step(); end
    idle(1'b0);
    chk("t2_full_count", 64'(q_count), 64'd4);
    chk("t2_full_en", 64'(rom_inst_en), 64'd0);
    chk("t2_full_addr", 64'(rom_inst_addr), 64'h1c000010);
    step();
    idle(1'b1);
    chk("t2_pop_en", 64'(rom_inst_en), 64'd1);
    chk("t2_pop_pc", 64'(id_pc), 64'h1c000000);
    step();
    idle(1'b0);
    chk("t2_after_count", 64'(q_count), 64'd4);
    chk("t2_after_pc", 64'(id_pc), 64'h1c000004);
    chk("t2_after_addr", 64'(rom_inst_addr), 64'h1c000014);
    step();

    // Branch with three entries queued
    restart(1'b0);
    idle(1'b0); step();
    repeat (3) begin idle(1'b0); step(); end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000100);
    chk("t3_count3", 64'(q_count), 64'd3);
    chk("t3_br_valid", 64'(id_valid), 64'd0);
    chk("t3_br_en", 64'(rom_inst_en), 64'd0);
    step();
    idle(1'b1);
    chk("t3_next_count", 64'(q_count), 64'd0);
    chk("t3_next_addr", 64'(rom_inst_addr), 64'h1c000100);
    step();
    idle(1'b1);
    chk("t3_target_pc", 64'(id_pc), 64'h1c000100);
    step();

    // Flush beats branch
    bad_fetch = 0;
    drive(1'b1, 1'b1, 32'h1c008000, 1'b1, 32'h1c000200);
    step();
    idle(1'b1);
    chk("t4_addr", 64'(rom_inst_addr), 64'h1c008000);
    step();
    repeat (6) begin idle(1'b1); step(); end
    chk("t4_no_branch_fetch", 64'(bad_fetch), 64'd0);

    // PC wrap
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hfffffffc);
    step();
    idle(1'b1);
    chk("t5_addr_fc", 64'(rom_inst_addr), 64'hfffffffc);
    chk("t5_en", 64'(rom_inst_en), 64'd1);
    step();
    idle(1'b1);
    chk("t5_addr_wrap", 64'(rom_inst_addr), 64'h0);
    chk("t5_head_fc", 64'(id_pc), 64'hfffffffc);
    step();

    // Asynchronous reset with a full queue
    repeat (5) begin idle(1'b0); step(); end
    idle(1'b0);
    chk("t6_full", 64'(q_count), 64'd4);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_en", 64'(rom_inst_en), 64'd0);
    chk("t6_async_valid", 64'(id_valid), 64'd0);
    chk("t6_async_count", 64'(q_count), 64'd0);
    model_reset();
    step();
    rst = 1'b1;
    idle(1'b1);
    chk("t6_rel_en", 64'(rom_inst_en), 64'd0);
    step();
    idle(1'b1);
    chk("t6_restart_en", 64'(rom_inst_en), 64'd1);
    chk("t6_restart_addr", 64'(rom_inst_addr), 64'h1c000000);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt_f, tgt_b;
      rst   = ($urandom_range(0, 99) != 0);
      tgt_f = ($urandom_range(0, 7) == 0) ? 32'hfffffff8 : RPC + 32'(4 * $urandom_range(0, 1023));
      tgt_b = RPC + 32'(4 * $urandom_range(0, 1023));
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, tgt_f,
            $urandom_range(0, 15) == 0, tgt_b);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Holds the PC and drives the ROM's enable and address, then captures the combinational instruction word the ROM returns.
- Buffers fetched {pc, inst} pairs in a small FIFO so decode stalls do not lose fetched instructions.
- Applies exception and branch redirects, flushing any wrong-path instructions.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- PC_W, 32, width of PC and ROM address.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rom_inst_en  out  1  ROM read enable.
- rom_inst_addr  out  PC_W  byte address of the current fetch; equals the PC register.
- rom_inst  in  INST_W  ROM data; combinational from rom_inst_addr, valid the same cycle.
- flush  in  1  exception/ertn redirect; highest priority.
- flush_pc  in  PC_W  target of flush.
- branch_flag  in  1  taken branch/jump redirect from execute.
- branch_target  in  PC_W  target of branch.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_valid  out  1  head entry valid.
- id_pc  out  PC_W  PC of the head entry.
- id_inst  out  INST_W  instruction of the head entry.
- q_count  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, ce=0, FIFO count=0, read/write pointers=0.
  - Outputs: rom_inst_en=0, id_valid=0, q_count=0.
  - id_pc and id_inst are don't-care while id_valid=0; the bench must not check them then.
- ce: a register set to 1 on the first rising edge with rst=1. The first fetch (addr RESET_PC) is therefore issued one cycle after reset release. ce stays 1 until the next reset.
- Definitions:
  - pop = id_valid & id_ready.
  - redirect = flush | branch_flag.
  - rom_inst_en = ce & ~redirect & (q_count<DEPTH | pop).
- Push: when rom_inst_en=1, {rom_inst_addr, rom_inst} is written at the write pointer on the edge, and pc <= pc+4.
- Stall: when rom_inst_en=0 and there is no redirect, pc holds.
- PC wrap: pc+4 is modulo 2^PC_W, so 0xFFFFFFFC is followed by 0x00000000.
- Redirect priority: flush over branch_flag when both are 1. On a redirect edge:
  - pc <= flush ? flush_pc : branch_target.
  - FIFO cleared: count=0, pointers=0.
  - No push and no pop in that cycle.
  - A redirect while ce=0 still loads pc; ce is unaffected.
- Redirect and id_valid: id_valid = (q_count!=0) & ~redirect. Head entries are killed combinationally in the redirect cycle.
- Target alignment: targets are used verbatim. No alignment check in this block.
- Simultaneous push and pop (no redirect):
  - count is unchanged and both pointers advance.
  - Allowed when full, i.e. the head leaves as the new entry enters.
- Full, no pop: rom_inst_en=0 and pc holds. No entry is overwritten.
- Empty: id_valid=0. No bypass from ROM to decode, so minimum fetch-to-decode latency is 1 cycle (entry visible the cycle after push).
- Ordering: entries leave in fetch order. id_pc and id_inst come from the head entry, with no extra register stage.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Reset mid-operation: everything returns to reset values immediately, including a full FIFO. The pending redirect is dropped.

Test Plan:
1. Reset release with id_ready=1 held.
   - Cycle 1: rom_inst_en=0.
   - Cycle 2: en=1, addr=0x1c000000.
   - Cycle 3: id_valid=1, id_pc=0x1c000000, id_inst=ROM[0].
   - Then id_pc increments by 4 every cycle.
2. Fill then stall: id_ready=0 from reset.
   - After 4 pushes: q_count=4, rom_inst_en=0, pc=0x1c000010 held.
   - Raise id_ready for 1 cycle: pops 0x1c000000 and simultaneously pushes 0x1c000010; q_count stays 4.
3. Branch with FIFO holding 3 entries: branch_flag=1, target=0x1c000100.
   - That cycle: id_valid=0, rom_inst_en=0.
   - Next cycle: q_count=0, addr=0x1c000100.
   - Following cycle: id_pc=0x1c000100.
4. flush=1 (flush_pc=0x1c008000) and branch_flag=1 (0x1c000200) in the same cycle: next fetch address is 0x1c008000; 0x1c000200 is never fetched.
5. Wrap: branch to 0xFFFFFFFC → next fetches are 0xFFFFFFFC then 0x00000000.
6. Assert rst=0 asynchronously mid-cycle with the FIFO full: rom_inst_en, id_valid and q_count go to 0 before the next edge; after release, fetch restarts at 0x1c000000.
